// File: rtl/intc_unit_if.sv
// intc_unit_if: the configuration bus and the core-side interrupt handshake of intc_unit.
//   cfg_we/cfg_addr/cfg_wdata -> register write strobe, select (0=MASK 1=PENDING 2=STATUS 3=CTRL) and data
//   cfg_rdata                 <- registered read data, valid one cycle after cfg_addr
//   irq_ack / eoi             -> core accepts the request / core finishes the handler
//   irq / irq_id / irq_vector <- request, source index and handler address
//   in_service                <- a handler is active
// The master modport is the core/configuration side; the slave modport is the controller.
interface intc_unit_if;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;
    logic        irq_ack;
    logic        eoi;
    logic        irq;
    logic [4:0]  irq_id;
    logic [31:0] irq_vector;
    logic        in_service;

    modport master (
        output cfg_we, cfg_addr, cfg_wdata, irq_ack, eoi,
        input  cfg_rdata, irq, irq_id, irq_vector, in_service
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata, irq_ack, eoi,
        output cfg_rdata, irq, irq_id, irq_vector, in_service
    );
endinterface

// File: rtl/intc_unit.sv
// intc_unit: edge-triggered interrupt controller in front of the processor core.
// Rising edges on src_irq latch into pending; pending & mask (gated by CTRL.en) is
// arbitrated with the lowest index winning, and the winner is presented on irq with
// its id and handler vector. Servicing uses an irq_ack / eoi handshake, no nesting.
// Ports:
//   clk      - system clock, all updates on the rising edge
//   reset    - synchronous, active-high reset
//   src_irq  - NUM_SRC raw request lines
//   bus      - intc_unit_if.slave: config bus and core handshake
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | nothing presented; arbitrate eligible requests
// REQ     | irq high for latched irq_id; wait for ack or withdraw
// SERVICE | handler running (in_service=1); wait for eoi
module intc_unit #(
    parameter int          NUM_SRC    = 8,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
    parameter int          VEC_STRIDE = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] src_irq,
    intc_unit_if.slave         bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    localparam logic [1:0] A_MASK    = 2'd0;
    localparam logic [1:0] A_PENDING = 2'd1;
    localparam logic [1:0] A_STATUS  = 2'd2;
    localparam logic [1:0] A_CTRL    = 2'd3;

    state_t state, state_n;

    logic [NUM_SRC-1:0] src_q;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] mask;
    logic               en;

    logic               irq_r, irq_n;
    logic [4:0]         id_r, id_n;
    logic [31:0]        vec_r, vec_n;
    logic               svc_r, svc_n;
    logic               ack_take;
    logic [31:0]        rdata_r, rdata_n;

    logic [NUM_SRC-1:0] edge_det;
    logic [NUM_SRC-1:0] eligible;
    logic [31:0]        eligible_w;
    logic [4:0]         winner;
    logic [31:0]        winner_vec;
    logic [31:0]        ack_clr_w;
    logic [NUM_SRC-1:0] clr;
    logic [NUM_SRC-1:0] pending_n;

    assign edge_det   = src_irq & ~src_q;
    assign eligible   = pending & mask & {NUM_SRC{en}};
    assign eligible_w = 32'(eligible);

    // Scan from the top so the lowest set index is the last one written.
    always_comb begin
        winner = 5'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) winner = 5'(i);
        end
    end

    assign winner_vec = VEC_BASE + 32'(winner) * 32'(VEC_STRIDE);

    always_comb begin
        state_n  = state;
        irq_n    = irq_r;
        id_n     = id_r;
        vec_n    = vec_r;
        svc_n    = svc_r;
        ack_take = 1'b0;
        case (state)
            ST_IDLE: begin
                if (|eligible) begin
                    state_n = ST_REQ;
                    irq_n   = 1'b1;
                    id_n    = winner;
                    vec_n   = winner_vec;
                end
            end
            ST_REQ: begin
                // Ack wins over a withdraw in the same cycle.
                if (bus.irq_ack) begin
                    ack_take = 1'b1;
                    state_n  = ST_SERVICE;
                    irq_n    = 1'b0;
                    svc_n    = 1'b1;
                end else if (!eligible_w[id_r]) begin
                    state_n = ST_IDLE;
                    irq_n   = 1'b0;
                end
            end
            ST_SERVICE: begin
                if (bus.eoi) begin
                    state_n = ST_IDLE;
                    svc_n   = 1'b0;
                end
            end
            default: begin
                state_n = ST_IDLE;
                irq_n   = 1'b0;
                svc_n   = 1'b0;
            end
        endcase
    end

    // Clears are applied before sets, so a coincident edge keeps the bit pending.
    assign ack_clr_w = ack_take ? (32'd1 << id_r) : 32'd0;
    assign clr       = ack_clr_w[NUM_SRC-1:0]
                     | ((bus.cfg_we && bus.cfg_addr == A_PENDING) ? bus.cfg_wdata[NUM_SRC-1:0]
                                                                   : {NUM_SRC{1'b0}});
    assign pending_n = (pending & ~clr) | edge_det;

    always_comb begin
        rdata_n = 32'd0;
        case (bus.cfg_addr)
            A_MASK:    rdata_n = 32'(mask);
            A_PENDING: rdata_n = 32'(pending);
            A_STATUS:  rdata_n = {22'd0, state, 2'b00, svc_r, id_r};
            A_CTRL:    rdata_n = {31'd0, en};
            default:   rdata_n = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            src_q   <= '0;
            pending <= '0;
            mask    <= '0;
            en      <= 1'b0;
            irq_r   <= 1'b0;
            id_r    <= 5'd0;
            vec_r   <= 32'd0;
            svc_r   <= 1'b0;
            rdata_r <= 32'd0;
        end else begin
            src_q   <= src_irq;
            pending <= pending_n;
            irq_r   <= irq_n;
            id_r    <= id_n;
            vec_r   <= vec_n;
            svc_r   <= svc_n;
            rdata_r <= rdata_n;
            if (bus.cfg_we && bus.cfg_addr == A_MASK) mask <= bus.cfg_wdata[NUM_SRC-1:0];
            if (bus.cfg_we && bus.cfg_addr == A_CTRL) en   <= bus.cfg_wdata[0];
        end
    end

    assign bus.irq        = irq_r;
    assign bus.irq_id     = id_r;
    assign bus.irq_vector = vec_r;
    assign bus.in_service = svc_r;
    assign bus.cfg_rdata  = rdata_r;

endmodule

// File: tb/tb_intc_unit.sv
module tb_intc_unit;
    localparam int          NS    = 8;
    localparam logic [31:0] VBASE = 32'h0000_0100;

    logic          clk = 1'b0;
    logic          reset;
    logic [NS-1:0] src;

    intc_unit_if bus();

    intc_unit #(.NUM_SRC(NS), .VEC_BASE(VBASE), .VEC_STRIDE(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .src_irq (src),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        irq;
        logic        svc;
        logic [4:0]  id;
        logic [31:0] vec;
        logic [31:0] rd;
    } exp_t;

    exp_t exp_q[$];
    int   compared   = 0;
    int   mismatched = 0;

    // Reference model: behaviour stated directly as the controller's rules.
    bit [NS-1:0] m_pend, m_mask, m_prev;
    bit          m_en;
    bit          m_presenting, m_handling;
    int          m_cur;
    logic [31:0] m_vec;

    always @(posedge clk) begin
        exp_t        e;
        bit [NS-1:0] elig, clr;
        logic [31:0] rd;
        int          best;
        if (reset) begin
            m_pend = '0; m_mask = '0; m_prev = '0; m_en = 0;
            m_presenting = 0; m_handling = 0; m_cur = 0; m_vec = 32'd0;
            rd = 32'd0;
        end else begin
            elig = m_en ? (m_pend & m_mask) : '0;
            case (bus.cfg_addr)
                2'd0:    rd = 32'(m_mask);
                2'd1:    rd = 32'(m_pend);
                2'd2:    rd = ((m_presenting ? 32'd1 : m_handling ? 32'd2 : 32'd0) << 8)
                            | (m_handling ? 32'h20 : 32'h0) | 32'(m_cur);
                default: rd = {31'd0, m_en};
            endcase
            clr = '0;
            if (m_presenting) begin
                if (bus.irq_ack) begin
                    clr[m_cur]   = 1'b1;
                    m_presenting = 0;
                    m_handling   = 1;
                end else if (!elig[m_cur]) begin
                    m_presenting = 0;
                end
            end else if (m_handling) begin
                if (bus.eoi) m_handling = 0;
            end else if (elig != 0) begin
                best = -1;
                for (int i = 0; i < NS; i++) if (elig[i] && best < 0) best = i;
                m_cur        = best;
                m_vec        = VBASE + 32'(best) * 32'd4;
                m_presenting = 1;
            end
            if (bus.cfg_we && bus.cfg_addr == 2'd1) clr = clr | bus.cfg_wdata[NS-1:0];
            m_pend = (m_pend & ~clr) | (src & ~m_prev);
            if (bus.cfg_we && bus.cfg_addr == 2'd0) m_mask = bus.cfg_wdata[NS-1:0];
            if (bus.cfg_we && bus.cfg_addr == 2'd3) m_en = bus.cfg_wdata[0];
            m_prev = src;
        end
        e.irq = m_presenting;
        e.svc = m_handling;
        e.id  = 5'(m_cur);
        e.vec = m_vec;
        e.rd  = rd;
        exp_q.push_back(e);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    // Monitor: outputs settle after each rising edge and are sampled on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL scoreboard_empty: got no expected entry at %0t", $time);
        end else begin
            e = exp_q.pop_front();
            chk("irq",        32'(bus.irq),        32'(e.irq));
            chk("in_service", 32'(bus.in_service), 32'(e.svc));
            chk("irq_id",     32'(bus.irq_id),     32'(e.id));
            chk("irq_vector", bus.irq_vector,      e.vec);
            chk("cfg_rdata",  bus.cfg_rdata,       e.rd);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
        bus.cfg_we = 1'b1; bus.cfg_addr = a; bus.cfg_wdata = d;
        tick();
        bus.cfg_we = 1'b0; bus.cfg_wdata = 32'd0;
    endtask

    task automatic pulse_src(input int i);
        src[i] = 1'b1;
        tick();
        src[i] = 1'b0;
    endtask

    task automatic do_ack();
        bus.irq_ack = 1'b1; tick(); bus.irq_ack = 1'b0;
    endtask

    task automatic do_eoi();
        bus.eoi = 1'b1; tick(); bus.eoi = 1'b0;
    endtask

    task automatic wait_irq(input string name, input int budget);
        int n = 0;
        while (!bus.irq && n < budget) begin
            tick();
            n++;
        end
        compared++;
        if (!bus.irq) begin
            mismatched++;
            $display("FAIL %s: got irq=0 expected irq=1 within %0d cycles", name, budget);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic setup();
        cfg_write(2'd0, 32'hFF);
        cfg_write(2'd3, 32'h1);
    endtask

    initial begin
        reset = 1'b1; src = '0;
        bus.cfg_we = 1'b0; bus.cfg_addr = 2'd1; bus.cfg_wdata = 32'd0;
        bus.irq_ack = 1'b0; bus.eoi = 1'b0;
        tick(); tick();
        reset = 1'b0;

        // single source, latency and vector
        setup();
        bus.cfg_addr = 2'd1;
        pulse_src(3);
        tick();
        wait_irq("single_src3", 5);
        do_ack(); tick(); do_eoi(); tick(); tick();

        // simultaneous sources, lowest index first
        src[5] = 1'b1; src[2] = 1'b1; tick(); src = '0;
        wait_irq("pair_first", 5);
        do_ack(); tick();
        bus.cfg_addr = 2'd2;
        do_eoi();
        wait_irq("pair_second", 5);
        do_ack(); do_eoi(); tick();

        // withdraw by pending clear, then by mask
        bus.cfg_addr = 2'd1;
        pulse_src(4);
        wait_irq("withdraw_clr", 5);
        cfg_write(2'd1, 32'h10);
        tick(); tick(); tick();
        pulse_src(4);
        wait_irq("withdraw_mask", 5);
        cfg_write(2'd0, 32'hEF);
        tick(); tick(); tick();
        bus.cfg_addr = 2'd0;
        cfg_write(2'd0, 32'hFF);
        wait_irq("remask", 5);
        do_ack(); do_eoi(); tick();

        // level-held source pends once
        bus.cfg_addr = 2'd1;
        src[1] = 1'b1;
        repeat (3) tick();
        do_ack(); tick(); do_eoi();
        repeat (15) tick();
        src[1] = 1'b0;
        tick();

        // edge coincident with eoi, then no nesting
        pulse_src(6);
        wait_irq("svc6", 5);
        do_ack(); tick();
        src[6] = 1'b1; bus.eoi = 1'b1; tick();
        src[6] = 1'b0; bus.eoi = 1'b0;
        wait_irq("svc6_again", 5);
        do_ack();
        pulse_src(0);
        repeat (3) tick();
        do_eoi();
        wait_irq("after_nest", 5);
        do_ack(); do_eoi(); tick();

        // reset during REQ and during SERVICE
        pulse_src(2);
        wait_irq("pre_reset_req", 5);
        do_reset();
        pulse_src(2);
        repeat (4) tick();
        setup();
        pulse_src(3);
        wait_irq("pre_reset_svc", 5);
        do_ack(); tick();
        do_reset();
        pulse_src(5);
        repeat (4) tick();

        // randomized traffic
        setup();
        for (int c = 0; c < 4000; c++) begin
            src = src ^ (NS'($urandom) & NS'($urandom) & NS'($urandom));
            bus.irq_ack  = ($urandom_range(0, 3) == 0);
            bus.eoi      = ($urandom_range(0, 3) == 0);
            bus.cfg_addr = 2'($urandom_range(0, 3));
            bus.cfg_we   = ($urandom_range(0, 15) == 0);
            if (bus.cfg_addr == 2'd3) bus.cfg_wdata = {$urandom, ($urandom_range(0, 9) != 0)};
            else if (bus.cfg_addr == 2'd0) bus.cfg_wdata = $urandom | $urandom;
            else bus.cfg_wdata = $urandom & $urandom;
            reset = ($urandom_range(0, 499) == 0);
            tick();
        end
        reset = 1'b0; src = '0; bus.cfg_we = 1'b0; bus.irq_ack = 1'b0; bus.eoi = 1'b0;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
